// File: rtl/shift_register_arb_pkg.sv
// Shared types and helpers for the round-robin register-stage arbiter.
package shift_register_arb_pkg;

  // Pointer/owner storage width; covers arbiters of up to 2**16 requesters.
  localparam int unsigned ARB_PTR_W = 16;

  function automatic int unsigned idx_w(input int unsigned m);
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

  typedef struct packed {
    logic [ARB_PTR_W-1:0] ptr;
    logic                 locked;
    logic [ARB_PTR_W-1:0] owner;
  } arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// One-hot pick of the first request at or above ptr, wrapping modulo M.
module rr_priority_pick #(
  parameter int unsigned M  = 4,
  parameter int unsigned PW = 16
) (
  input  logic [M-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [M-1:0]  sel
);

  logic [M-1:0] rot;
  logic [M-1:0] ffs;
  logic         found;
  int           p;
  int           src;

  // Rotate so req[ptr] lands at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    rot   = '0;
    ffs   = '0;
    sel   = '0;
    found = 1'b0;
    p     = int'(ptr);
    src   = 0;
    for (int k = 0; k < int'(M); k++) begin
      src = (k + p >= int'(M)) ? (k + p - int'(M)) : (k + p);
      for (int s = 0; s < int'(M); s++) begin
        if (s == src) rot[k] = req[s];
      end
    end
    for (int k = 0; k < int'(M); k++) begin
      if (rot[k] && !found) begin
        ffs[k] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int k = 0; k < int'(M); k++) begin
      src = (k + p >= int'(M)) ? (k + p - int'(M)) : (k + p);
      for (int s = 0; s < int'(M); s++) begin
        if (s == src && ffs[k]) sel[s] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shift_register_rr_arbiter.sv
// Round-robin arbiter feeding M requesters into one shared N-bit output register.
// Optional burst lock enabled by defining SHIFT_REGISTER_ARB_LOCK_EN.
module shift_register_rr_arbiter
  import shift_register_arb_pkg::*;
#(
  parameter int unsigned N = 2,
  parameter int unsigned M = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [M-1:0]         req,
  input  logic [M*N-1:0]       PI,
  output logic [M-1:0]         gnt,
  output logic [N-1:0]         PO,
  output logic                 po_valid,
  output logic [idx_w(M)-1:0]  po_src,
  input  logic                 po_ready
`ifdef SHIFT_REGISTER_ARB_LOCK_EN
  ,
  input  logic [M-1:0]         lock
`endif
);

  localparam int unsigned IW = idx_w(M);
  localparam int unsigned PW = ARB_PTR_W;
  localparam logic [PW-1:0] LAST = PW'(M - 1);

  logic          accept;
  logic          xfer;
  logic [M-1:0]  req_eff;
  logic [M-1:0]  sel;
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] nxt_ptr;
  logic [N-1:0]  win_word;

  assign accept = !po_valid || po_ready;

  rr_priority_pick #(
    .M  (M),
    .PW (PW)
  ) u_pick (
    .req (req_eff),
    .ptr (ptr_q),
    .sel (sel)
  );

  // Grant only when the register can take a word; reset blocks any transfer.
  assign gnt  = (accept && !rst) ? sel : '0;
  assign xfer = |gnt;

  always_comb begin
    win_idx  = '0;
    win_word = '0;
    for (int i = 0; i < int'(M); i++) begin
      if (gnt[i]) begin
        win_idx  = win_idx | PW'(i);
        win_word = win_word | PI[i*N +: N];
      end
    end
  end

  assign nxt_ptr = (win_idx == LAST) ? '0 : win_idx + PW'(1);

  // Shared output register with valid/ready drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      PO       <= '0;
      po_valid <= 1'b0;
      po_src   <= '0;
    end else if (xfer) begin
      PO       <= win_word;
      po_valid <= 1'b1;
      po_src   <= IW'(win_idx);
    end else if (po_ready) begin
      po_valid <= 1'b0;
    end
  end

`ifdef SHIFT_REGISTER_ARB_LOCK_EN
  arb_state_t st_q;
  logic       lock_win;
  logic       owner_req;

  assign ptr_q    = st_q.ptr;
  assign lock_win = |(gnt & lock);

  // While locked, only the owner may compete.
  always_comb begin
    req_eff   = '0;
    owner_req = 1'b0;
    for (int i = 0; i < int'(M); i++) begin
      req_eff[i] = req[i] && (!st_q.locked || (st_q.owner == PW'(i)));
      if (st_q.owner == PW'(i)) owner_req = req[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= '0;
    end else if (xfer) begin
      st_q.ptr    <= nxt_ptr;
      st_q.locked <= lock_win;
      st_q.owner  <= win_idx;
    end else if (st_q.locked && !owner_req) begin
      st_q.locked <= 1'b0;
    end
  end
`else
  assign req_eff = req;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (xfer) begin
      ptr_q <= nxt_ptr;
    end
  end
`endif

endmodule

// File: tb/tb_shift_register_rr_arbiter.sv
// Directed + random bench for shift_register_rr_arbiter (N=8, M=4) with a reference model and scoreboard.
module tb_shift_register_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] PI;
  logic [3:0]  gnt;
  logic [7:0]  PO;
  logic        po_valid;
  logic [1:0]  po_src;
  logic        po_ready;
  logic [3:0]  lock;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [1:0]  m_ptr;
  logic        m_valid;
  logic        m_locked;
  logic [1:0]  m_owner;
  logic [7:0]  m_po;
  logic [1:0]  m_src;
  logic [9:0]  sb_q[$];

  shift_register_rr_arbiter #(
    .N (8),
    .M (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .PI       (PI),
    .gnt      (gnt),
    .PO       (PO),
    .po_valid (po_valid),
    .po_src   (po_src),
    .po_ready (po_ready)
`ifdef SHIFT_REGISTER_ARB_LOCK_EN
    ,
    .lock     (lock)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Search upward from the model pointer by distance.
  function automatic logic [3:0] model_gnt();
    logic [3:0] r;
    logic [1:0] s;
    r = req;
    if (rst || (m_valid && !po_ready)) return 4'b0000;
    if (m_locked) r = r & (4'b0001 << m_owner);
    for (int d = 0; d < 4; d++) begin
      s = m_ptr + 2'(d);
      if (r[s]) return 4'b0001 << s;
    end
    return 4'b0000;
  endfunction

  // One clock: check grant, advance model, check registered outputs.
  task automatic tick(input string tag);
    logic [3:0]  eg;
    logic [1:0]  w;
    logic [31:0] sh;
    logic [9:0]  ent;
    #1;
    eg = model_gnt();
    chk({tag, "/gnt"}, 32'(gnt), 32'(eg));
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_valid = 0; m_locked = 0; m_po = 0; m_src = 0;
      sb_q.delete();
    end else if (eg != 4'b0000) begin
      w = 0;
      for (int i = 0; i < 4; i++) if (eg[i]) w = 2'(i);
      sh = PI >> {w, 3'b000};
      sb_q.push_back({sh[7:0], w});
      m_valid  = 1'b1;
      m_ptr    = w + 2'd1;
      m_locked = lock[w];
      m_owner  = w;
    end else begin
      if (po_ready) m_valid = 1'b0;
      if (m_locked && !req[m_owner]) m_locked = 1'b0;
    end
    #1;
    if (sb_q.size() != 0) begin
      ent   = sb_q.pop_front();
      m_po  = ent[9:2];
      m_src = ent[1:0];
    end
    chk({tag, "/po_valid"}, 32'(po_valid), 32'(m_valid));
    chk({tag, "/PO"}, 32'(PO), 32'(m_po));
    chk({tag, "/po_src"}, 32'(po_src), 32'(m_src));
    @(negedge clk);
  endtask

  int         exp_src[5];
  logic [7:0] exp_po[5];

  initial begin
    exp_src = '{0, 1, 2, 3, 0};
    exp_po  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    m_ptr = 0; m_valid = 0; m_locked = 0; m_owner = 0; m_po = 0; m_src = 0;
    rst = 1'b1; req = 4'b1111; PI = 32'h44332211; po_ready = 1'b1; lock = 4'b0000;
    @(negedge clk);

    // Reset held two cycles with all requests high
    tick("reset0");
    tick("reset1");
    chk("reset/gnt", 32'(gnt), 32'h0);
    chk("reset/po_valid", 32'(po_valid), 32'h0);
    chk("reset/PO", 32'(PO), 32'h0);
    chk("reset/po_src", 32'(po_src), 32'h0);
    rst = 1'b0;
    #1 chk("first_grant", 32'(gnt), 32'h1);

    // Round-robin rotation under full request load
    for (int k = 0; k < 5; k++) begin
      tick("rr");
      chk("rr/src_seq", 32'(po_src), 32'(exp_src[k]));
      chk("rr/po_seq", 32'(PO), 32'(exp_po[k]));
      chk("rr/valid", 32'(po_valid), 32'h1);
    end

    // Backpressure: word held, no grants
    po_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick("stall");
      chk("stall/PO_hold", 32'(PO), 32'h11);
      chk("stall/gnt0", 32'(gnt), 32'h0);
    end
    po_ready = 1'b1;
    #1 chk("unstall/gnt1", 32'(gnt), 32'h2);
    tick("unstall");

    // Sparse: wrap from ptr=2 to requester 0, then drain
    req = 4'b0001;
    #1 chk("sparse/wrap", 32'(gnt), 32'h1);
    tick("sparse");
    req = 4'b0000;
    tick("drain");
    chk("drain/valid", 32'(po_valid), 32'h0);
    chk("drain/PO_keep", 32'(PO), 32'h11);
    req = 4'b1111;
    #1 chk("drain/ptr1", 32'(gnt), 32'h2);
    tick("after_drain");

    // Reset coinciding with requester 2's turn
    rst = 1'b1;
    #1 chk("midrst/gnt", 32'(gnt), 32'h0);
    tick("midrst");
    chk("midrst/valid", 32'(po_valid), 32'h0);
    rst = 1'b0;
    #1 chk("midrst/next", 32'(gnt), 32'h1);
    tick("post_rst");

    // Random traffic against the model
    for (int k = 0; k < 80; k++) begin
      req      = 4'($urandom_range(0, 15));
      po_ready = ($urandom_range(0, 3) != 0);
      PI       = $urandom;
      rst      = ($urandom_range(0, 40) == 0);
`ifdef SHIFT_REGISTER_ARB_LOCK_EN
      lock     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
`endif
      tick("rand");
    end
    rst = 1'b0; lock = 4'b0000;

`ifdef SHIFT_REGISTER_ARB_LOCK_EN
    // Burst lock on requester 1
    rst = 1'b1; req = 4'b1111; po_ready = 1'b1; PI = 32'h44332211;
    tick("lk_rst");
    rst = 1'b0;
    tick("lk_first");
    lock = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1 chk("lock/gnt1", 32'(gnt), 32'h2);
      tick("lock");
      chk("lock/src1", 32'(po_src), 32'h1);
    end
    lock = 4'b0000;
    #1 chk("lock/last", 32'(gnt), 32'h2);
    tick("lock_last");
    #1 chk("lock/release", 32'(gnt), 32'h4);
    tick("lock_rel");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
